// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;
  localparam logic [31:0] ADDR_START_DEF = 32'h0100_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        filled;
  } fq_entry_t;

  function automatic int fq_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/fetch_queue_ram.sv
// Entry storage for the fetch queue: allocate writes pc, fill writes instr, head is read combinationally.
module fetch_queue_ram
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = fq_clog2(DEPTH)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            alloc_en_i,
  input  logic [AW-1:0]   alloc_idx_i,
  input  logic [31:0]     alloc_pc_i,
  input  logic            fill_en_i,
  input  logic [AW-1:0]   fill_idx_i,
  input  logic [31:0]     fill_instr_i,
  input  logic [AW-1:0]   rd_idx_i,
  output fq_entry_t       rd_entry_o
);

  fq_entry_t mem_q [DEPTH];

  // Allocate and fill never target the same slot in one cycle: a response
  // always belongs to a request accepted on an earlier cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (alloc_en_i) mem_q[alloc_idx_i] <= '{pc: alloc_pc_i, instr: NOP_INSTR, filled: 1'b0};
      if (fill_en_i) begin
        mem_q[fill_idx_i].instr  <= fill_instr_i;
        mem_q[fill_idx_i].filled <= 1'b1;
      end
    end
  end

  assign rd_entry_o = mem_q[rd_idx_i];

endmodule

// File: rtl/fetch_queue.sv
// Decoupled fetch front end: owns the PC, issues imem reads, buffers responses in order.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH      = 4,
  parameter int          MAX_OUTST  = 2,
  parameter logic [31:0] ADDR_START = ADDR_START_DEF
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  input  logic        stall,
  output logic        d_valid,
  output logic [31:0] d_pc,
  output logic [31:0] d_instr
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cyc,
  output logic [31:0] perf_empty_cyc,
  output logic [31:0] perf_flush_cnt
`endif
);

  localparam int AW = fq_clog2(DEPTH);
  localparam int OW = fq_clog2(MAX_OUTST + 1);

  logic [31:0]   pc_q, pc_d;
  logic [AW-1:0] wr_q, wr_d, fill_q, fill_d, rd_q, rd_d;
  logic [AW:0]   occ_q, occ_d;
  logic [OW-1:0] outst_q, outst_d, drop_q, drop_d, outst_nx;
  logic          issue, rsp_drop, rsp_fill, pop, not_empty;
  fq_entry_t     head;

  // Gated by reset so no request is presented while the block is held in reset.
  assign imem_req_valid = reset && !redirect && (occ_q < (AW+1)'(DEPTH)) && (outst_q < OW'(MAX_OUTST));
  assign imem_req_addr  = pc_q;
  assign issue          = imem_req_valid && imem_req_ready;
  assign rsp_drop       = imem_rsp_valid && (drop_q != '0);
  assign rsp_fill       = imem_rsp_valid && (drop_q == '0);

  assign not_empty = (occ_q != '0);
  assign d_valid   = not_empty && head.filled;
  assign d_pc      = not_empty ? head.pc : pc_q;
  assign d_instr   = d_valid ? head.instr : NOP_INSTR;
  assign pop       = !stall && !redirect && d_valid;

  always_comb begin
    outst_nx = outst_q + OW'(issue) - OW'(imem_rsp_valid);
    pc_d     = pc_q;
    wr_d     = wr_q;
    fill_d   = fill_q;
    rd_d     = rd_q;
    occ_d    = occ_q;
    drop_d   = drop_q;
    outst_d  = outst_nx;
    if (redirect) begin
      // Everything still in flight after this cycle is stale, including
      // nothing issued now (req_valid is low) and not the response landing now.
      wr_d   = rd_q;
      fill_d = rd_q;
      occ_d  = '0;
      pc_d   = {redirect_target[31:2], 2'b00};
      drop_d = outst_nx;
    end else begin
      if (issue) begin
        wr_d = wr_q + 1'b1;
        pc_d = pc_q + 32'd4;
      end
      if (rsp_fill) fill_d = fill_q + 1'b1;
      if (rsp_drop) drop_d = drop_q - 1'b1;
      if (pop)      rd_d   = rd_q + 1'b1;
      occ_d = occ_q + (AW+1)'(issue) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q    <= ADDR_START;
      wr_q    <= '0;
      fill_q  <= '0;
      rd_q    <= '0;
      occ_q   <= '0;
      outst_q <= '0;
      drop_q  <= '0;
    end else begin
      pc_q    <= pc_d;
      wr_q    <= wr_d;
      fill_q  <= fill_d;
      rd_q    <= rd_d;
      occ_q   <= occ_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
    end
  end

  fetch_queue_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clock        (clock),
    .reset        (reset),
    .alloc_en_i   (issue),
    .alloc_idx_i  (wr_q),
    .alloc_pc_i   (pc_q),
    .fill_en_i    (rsp_fill && !redirect),
    .fill_idx_i   (fill_q),
    .fill_instr_i (imem_rsp_data),
    .rd_idx_i     (rd_q),
    .rd_entry_o   (head)
  );

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_stall_cyc <= '0;
      perf_empty_cyc <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall && d_valid)     perf_stall_cyc <= perf_stall_cyc + 32'd1;
      if (!d_valid && !redirect) perf_empty_cyc <= perf_empty_cyc + 32'd1;
      if (redirect)             perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule
